// File: rtl/stage_sequencer.sv
// stage_sequencer
//   Walks a session through NUM_STAGES linear stages. Stage 0 is idle and
//   stage NUM_STAGES-1 is terminal. Raw switch/button inputs are debounced
//   here. The block supports back navigation, a per-stage choice of advance
//   event, an optional inactivity timeout, and stage-change strobes.
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   session_en  raw session switch, high enables sequencing
//   btn_next    raw advance button
//   btn_back    raw back button
//   save_req    raw store switch (the advance event on SAVE_MASK stages)
//   fsm_state   current stage index
//   prev_state  stage held before the most recent change
//   stage_enter one-cycle pulse on the first cycle of a new fsm_state
//   timeout     one-cycle pulse alongside stage_enter when inactivity forced idle
//
// stage             | meaning
// ------------------+-------------------------------------------------
// 0                 | idle, waits for a session_en rise
// 1..NUM_STAGES-2   | working stage, advances on next or save rise
// NUM_STAGES-1      | terminal, only back / session-off / timeout leave
// >= NUM_STAGES     | unreachable, recovers to idle

module stage_sequencer #(
  parameter int                    NUM_STAGES   = 6,
  parameter int                    STATE_W      = 3,
  parameter logic [NUM_STAGES-1:0] SAVE_MASK    = NUM_STAGES'(6'b001000),
  parameter int                    DEBOUNCE_CYC = 4,
  parameter int                    TIMEOUT_CYC  = 0,
  parameter int                    TO_W         = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               session_en,
  input  logic               btn_next,
  input  logic               btn_back,
  input  logic               save_req,
  output logic [STATE_W-1:0] fsm_state,
  output logic [STATE_W-1:0] prev_state,
  output logic               stage_enter,
  output logic               timeout
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int PAD  = 2 ** STATE_W;

  localparam logic [DB_W-1:0]    DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TO_W-1:0]    TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [STATE_W-1:0] ST_TERM = STATE_W'(NUM_STAGES - 1);
  localparam logic [STATE_W-1:0] ST_ONE  = STATE_W'(1);

  localparam int I_SES  = 0;
  localparam int I_NEXT = 1;
  localparam int I_BACK = 2;
  localparam int I_SAVE = 3;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_START,
    EV_STOP,
    EV_TIMEOUT,
    EV_BACK,
    EV_ADVANCE,
    EV_INVALID
  } event_t;

  logic [3:0]      raw;
  logic [3:0]      filt;
  logic [3:0]      rise;
  logic [3:0]      fall;
  logic [DB_W-1:0] db_cnt [4];

  logic [TO_W-1:0]    to_cnt;
  logic [PAD-1:0]     mask_ext;
  logic [STATE_W-1:0] next_state;
  logic               in_range;
  logic               is_idle;
  logic               is_term;
  logic               adv_evt;
  logic               to_hit;
  logic               any_edge;
  event_t             ev;

  assign raw      = {save_req, btn_back, btn_next, session_en};
  // Widened so the mask can be indexed by any fsm_state value.
  assign mask_ext = PAD'(SAVE_MASK);

  // Debounce: the filter flips only after DEBOUNCE_CYC consecutive
  // disagreeing samples. The edge flag is registered on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= '0;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        rise[i] <= 1'b0;
        fall[i] <= 1'b0;
        if (raw[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          filt[i]   <= raw[i];
          rise[i]   <= raw[i];
          fall[i]   <= ~raw[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign in_range = (fsm_state <= ST_TERM);
  assign is_idle  = (fsm_state == '0);
  assign is_term  = (fsm_state == ST_TERM);
  assign adv_evt  = mask_ext[fsm_state] ? rise[I_SAVE] : rise[I_NEXT];
  assign to_hit   = (TIMEOUT_CYC != 0) && (to_cnt == TO_LAST);
  assign any_edge = |{rise, fall};

  // Event decode in priority order, then next-state selection.
  always_comb begin
    ev         = EV_NONE;
    next_state = fsm_state;

    if (!in_range)            ev = EV_INVALID;
    else if (is_idle) begin
      if (rise[I_SES])        ev = EV_START;
    end
    else if (fall[I_SES])     ev = EV_STOP;
    else if (to_hit)          ev = EV_TIMEOUT;
    else if (rise[I_BACK])    ev = EV_BACK;
    else if (adv_evt && !is_term) ev = EV_ADVANCE;

    case (ev)
      EV_START:   next_state = ST_ONE;
      EV_STOP,
      EV_TIMEOUT,
      EV_INVALID: next_state = '0;
      // Back saturates at stage 1 and never re-enters idle.
      EV_BACK:    next_state = (fsm_state > ST_ONE) ? fsm_state - ST_ONE : fsm_state;
      EV_ADVANCE: next_state = fsm_state + ST_ONE;
      default:    next_state = fsm_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_state   <= '0;
      prev_state  <= '0;
      stage_enter <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      fsm_state   <= next_state;
      stage_enter <= (next_state != fsm_state);
      timeout     <= (ev == EV_TIMEOUT);
      if (next_state != fsm_state) prev_state <= fsm_state;
    end
  end

  // Inactivity counter: any filtered edge or stage change counts as activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (is_idle || any_edge || (next_state != fsm_state)) begin
      to_cnt <= '0;
    end else if (to_cnt != '1) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
module tb_stage_sequencer;

  localparam int NS  = 6;
  localparam int DEB = 4;
  localparam bit [5:0] MASK_TB = 6'b001000;
  localparam int TO_CFG0 = 0;
  localparam int TO_CFG1 = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic session_en = 1'b0;
  logic btn_next = 1'b0;
  logic btn_back = 1'b0;
  logic save_req = 1'b0;

  logic [2:0] st0, prev0, st1, prev1;
  logic       se0, to0, se1, to1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage_sequencer u_dut (
    .clk(clk), .rst(rst), .session_en(session_en), .btn_next(btn_next),
    .btn_back(btn_back), .save_req(save_req),
    .fsm_state(st0), .prev_state(prev0), .stage_enter(se0), .timeout(to0)
  );

  stage_sequencer #(.TIMEOUT_CYC(TO_CFG1)) u_dut_to (
    .clk(clk), .rst(rst), .session_en(session_en), .btn_next(btn_next),
    .btn_back(btn_back), .save_req(save_req),
    .fsm_state(st1), .prev_state(prev1), .stage_enter(se1), .timeout(to1)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. A filter flips once the last DEB raw samples all
  // disagree with it. Stage moves follow the event rules with plain integers.
  int m_st[2], m_prev[2], m_tcnt[2];
  bit m_se[2], m_to[2];
  bit [3:0] m_filt, m_rise, m_fall;
  bit [3:0] m_hist[$];
  bit model_valid = 1'b0;
  int m_ns;
  bit m_fire;
  bit m_adv;
  bit m_flip;

  function automatic int to_cfg(input int i);
    return (i == 0) ? TO_CFG0 : TO_CFG1;
  endfunction

  function automatic bit save_stage(input int k);
    return ((MASK_TB >> k) & 6'd1) != 0;
  endfunction

  always @(posedge clk) begin
    model_valid <= 1'b1;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_st[i] = 0; m_prev[i] = 0; m_tcnt[i] = 0; m_se[i] = 0; m_to[i] = 0;
      end
      m_filt = '0; m_rise = '0; m_fall = '0;
      m_hist.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_ns = m_st[i];
        m_fire = 1'b0;
        m_adv = save_stage(m_st[i]) ? m_rise[3] : m_rise[1];
        if (m_st[i] == 0) begin
          if (m_rise[0]) m_ns = 1;
        end else if (m_fall[0]) begin
          m_ns = 0;
        end else if (to_cfg(i) != 0 && m_tcnt[i] == to_cfg(i) - 1) begin
          m_ns = 0;
          m_fire = 1'b1;
        end else if (m_rise[2]) begin
          m_ns = (m_st[i] > 1) ? m_st[i] - 1 : 1;
        end else if (m_adv && m_st[i] < NS - 1) begin
          m_ns = m_st[i] + 1;
        end
        if (m_st[i] == 0 || (m_rise | m_fall) != 0 || m_ns != m_st[i]) m_tcnt[i] = 0;
        else m_tcnt[i] = m_tcnt[i] + 1;
        m_se[i] = (m_ns != m_st[i]);
        m_to[i] = m_fire;
        if (m_ns != m_st[i]) m_prev[i] = m_st[i];
        m_st[i] = m_ns;
      end
      m_hist.push_back({save_req, btn_back, btn_next, session_en});
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      for (int j = 0; j < 4; j++) begin
        m_flip = (m_hist.size() == DEB);
        foreach (m_hist[k]) if (m_hist[k][j] == m_filt[j]) m_flip = 1'b0;
        m_rise[j] = m_flip && !m_filt[j];
        m_fall[j] = m_flip && m_filt[j];
        if (m_flip) m_filt[j] = ~m_filt[j];
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("state",      int'(st0),   m_st[0]);
      check("prev",       int'(prev0), m_prev[0]);
      check("enter",      int'(se0),   int'(m_se[0]));
      check("timeout",    int'(to0),   int'(m_to[0]));
      check("to_state",   int'(st1),   m_st[1]);
      check("to_prev",    int'(prev1), m_prev[1]);
      check("to_enter",   int'(se1),   int'(m_se[1]));
      check("to_timeout", int'(to1),   int'(m_to[1]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_next();
    btn_next = 1'b1; cyc(6);
    btn_next = 1'b0; cyc(8);
  endtask

  task automatic press_back();
    btn_back = 1'b1; cyc(6);
    btn_back = 1'b0; cyc(8);
  endtask

  task automatic wait_to_stage2(output bit found);
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge clk);
      if (se1 && st1 == 3'd2) found = 1'b1;
    end
  endtask

  initial begin
    int n;
    bit found;

    cyc(3);
    rst = 1'b0;
    cyc(1);
    check("rst_state", int'(st0), 0);
    check("rst_prev", int'(prev0), 0);

    // Session rise latency: state changes on the 5th edge after first sample.
    session_en = 1'b1;
    cyc(4);
    check("lat_before", int'(st0), 0);
    cyc(1);
    check("lat_state", int'(st0), 1);
    check("lat_enter", int'(se0), 1);
    check("lat_prev", int'(prev0), 0);
    cyc(4);

    press_next();
    check("next_to_2", int'(st0), 2);
    btn_next = 1'b1; cyc(3); btn_next = 1'b0; cyc(8);
    check("glitch", int'(st0), 2);
    press_next();
    check("next_to_3", int'(st0), 3);
    press_next();
    check("save_stage_ignores_next", int'(st0), 3);
    save_req = 1'b1; cyc(8);
    check("save_to_4", int'(st0), 4);
    press_next();
    check("next_to_5", int'(st0), 5);
    press_next();
    check("terminal_hold", int'(st0), 5);
    press_back();
    check("back_to_4", int'(st0), 4);
    btn_back = 1'b1; session_en = 1'b0; cyc(8);
    check("off_beats_back", int'(st0), 0);
    check("off_prev", int'(prev0), 4);
    btn_back = 1'b0; save_req = 1'b0; cyc(8);
    session_en = 1'b1; cyc(8);
    check("restart_1", int'(st0), 1);
    press_back();
    check("back_saturates", int'(st0), 1);

    // Timeout: 100 quiet cycles in stage 2 force idle.
    btn_next = 1'b1;
    wait_to_stage2(found);
    check("to_reach_2", int'(found), 1);
    n = 0; found = 1'b0;
    while (n < 150 && !found) begin
      @(negedge clk); n++;
      if (to1) found = 1'b1;
    end
    check("to_cycles", n, 100);
    check("to_idle", int'(st1), 0);
    check("to_pulse_enter", int'(se1), 1);
    check("to_prev_2", int'(prev1), 2);
    check("no_to_instance", int'(st0), 2);

    // Activity around cycle 60 restarts the count.
    btn_next = 1'b0; session_en = 1'b0; cyc(10);
    session_en = 1'b1; cyc(8);
    btn_next = 1'b1;
    wait_to_stage2(found);
    check("to_reach_2b", int'(found), 1);
    cyc(56);
    btn_next = 1'b0;
    cyc(44);
    check("to_restarted", int'(st1), 2);
    n = 100; found = 1'b0;
    while (n < 250 && !found) begin
      @(negedge clk); n++;
      if (to1) found = 1'b1;
    end
    check("to_cycles_restart", n, 161);

    // Reset mid-session with btn_next mid-debounce.
    rst = 1'b1; cyc(2); rst = 1'b0;
    session_en = 1'b1; cyc(8);
    press_next(); press_next();
    save_req = 1'b1; cyc(8);
    press_next();
    check("climb_5", int'(st0), 5);
    btn_next = 1'b1; cyc(2);
    rst = 1'b1; btn_next = 1'b0; session_en = 1'b0; save_req = 1'b0;
    cyc(1);
    check("rst_mid_state", int'(st0), 0);
    check("rst_mid_prev", int'(prev0), 0);
    check("rst_mid_enter", int'(se0), 0);
    check("rst_mid_timeout", int'(to0), 0);
    rst = 1'b0;
    cyc(20);
    check("post_rst_idle", int'(st0), 0);
    check("post_rst_idle_to", int'(st1), 0);

    // Randomized phase against the model.
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1; cyc($urandom_range(1, 3)); rst = 1'b0;
      end
      session_en = ($urandom_range(0, 9) != 0);
      btn_next   = ($urandom_range(0, 2) == 0);
      btn_back   = ($urandom_range(0, 5) == 0);
      save_req   = ($urandom_range(0, 3) == 0);
      cyc($urandom_range(1, 10));
    end
    btn_next = 1'b0; btn_back = 1'b0; save_req = 1'b0;
    cyc(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got 0 exp 1");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Parametrised successor to the project's top-level mode FSM. Sequences a session through NUM_STAGES linear stages: stage 0 is idle, stage NUM_STAGES-1 is terminal.
- Adds debounce of raw button/switch inputs, back navigation, per-stage selection of the advance event, an inactivity timeout, and stage-change strobes.
- Sits between the debounced-IO layer and datapath stages (background select, colour edits, overlays, BRAM store, PC upload), which decode fsm_state.

Parameters:
- NUM_STAGES, 6, total stages including idle (stage 0); legal range 3..2**STATE_W.
- STATE_W, 3, width of fsm_state and prev_state.
- SAVE_MASK, 6'b001000, bit k=1: stage k advances on save_req rising, not btn_next rising; width NUM_STAGES; bits 0 and NUM_STAGES-1 ignored.
- DEBOUNCE_CYC, 4, consecutive samples a raw input must differ from its filtered level before the filter flips; must be >=1.
- TIMEOUT_CYC, 0, inactivity cycles before forced return to idle; 0 disables.
- TO_W, 32, timeout counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- session_en  in  1  raw session switch; high enables sequencing
- btn_next  in  1  raw advance button
- btn_back  in  1  raw back button
- save_req  in  1  raw store switch
- fsm_state  out  STATE_W  current stage index
- prev_state  out  STATE_W  stage held before the most recent change
- stage_enter  out  1  one-cycle pulse on the first cycle fsm_state holds a new value
- timeout  out  1  one-cycle pulse coincident with stage_enter when a timeout forced idle

Behaviour:
- Reset (rst high at a clk edge):
  - fsm_state=0, prev_state=0, stage_enter=0, timeout=0.
  - All filtered levels, edge flags, debounce counters and the timeout counter = 0.
- Debounce, per input, independently:
  - Counter increments while raw != filtered; clears when raw == filtered.
  - When the counter reaches DEBOUNCE_CYC, the filter flips on that edge and the counter clears.
- Edges:
  - rise/fall flags are registered, true for exactly one cycle after the filter flips.
  - The state register acts on them at the next edge.
- Latency: a clean raw transition first sampled at edge 1 changes fsm_state at edge DEBOUNCE_CYC+1.
- Priority when events coincide: session fall > timeout > back rise > advance event.
- Transitions:
  - Idle(0): session rise -> 1. Every other event is ignored.
  - Stage k, 1<=k<=NUM_STAGES-2: advance event -> k+1.
  - Advance event is save rise if SAVE_MASK[k], else next rise. The non-selected one is ignored.
  - Any stage k>=1: back rise -> k-1, saturating at 1. Back never enters idle.
  - Terminal stage: advance events are ignored; back applies.
  - Any stage k>=1: session fall -> 0.
- A session level that is high through reset filters up after DEBOUNCE_CYC cycles and produces a rise, so the block enters stage 1.
- Timeout counter:
  - Clears on any filtered edge, on any state change, and while in idle.
  - Otherwise increments, saturating at all-ones.
  - When TIMEOUT_CYC!=0, fsm_state!=0 and count==TIMEOUT_CYC-1 at an edge: fsm_state -> 0 and timeout pulses next cycle.
- Any change of fsm_state loads prev_state with the old value and pulses stage_enter. A self-loop never pulses.
- Asserting rst mid-debounce or mid-session discards all pending counts and flags. No event fires from pre-reset state.
- Out-of-range fsm_state (not reachable) -> 0 on the next edge.

Test Plan:
- Defaults, session_en rises and holds clean -> fsm_state 0->1 exactly 5 edges after first sample; stage_enter one pulse; prev_state=0.
- From stage 1, pulse btn_next high for 6 cycles twice (debounced) -> states 2 then 3. At 3, btn_next is ignored; save_req rise -> 4; btn_next rise -> 5; further btn_next stays 5.
- btn_next glitch high for 3 cycles at stage 2 (DEBOUNCE_CYC=4) -> no change, no stage_enter.
- At stage 1, btn_back rise -> stays 1, no pulse. At stage 4, back rise and session fall land in the same cycle -> fsm_state=0, prev_state=4.
- TIMEOUT_CYC=100, enter stage 2 and leave inputs idle -> state 0 after 100 cycles in stage 2, timeout and stage_enter pulse together. A btn activity edge at cycle 60 restarts the count.
- rst asserted at stage 5 with btn_next mid-debounce -> all outputs 0 next cycle; no spurious transition after release while inputs stay low.
